psum_collector: RTL and testbench
=================================

# psum_collector

Output-stationary partial-sum buffer at the bottom of the `PE_column` array: it drives each column lane's `psum_in` and captures each lane's `psum_out`. It handles the diagonal skew of the column, where lane k sees pixel data k cycles after lane 0. It accumulates over a configured number of passes, then binarizes the final sums against a threshold and emits one O_CH-bit activation word per pixel to the next layer.

## Interface
- WIDTH, 14, psum width per lane (signed two's complement)
- O_CH, 64, lanes (output channels) in the column
- DEPTH, 16, pixels buffered per lane
- PE_LAT, 1, cycles from a lane's psum_in presentation to its psum_out result
- clk_in  input  1  clock
- rst_in  input  1  reset, synchronous, active-high
- cfg_valid_in  input  1  tile configuration strobe
- cfg_ready_out  output  1  high only in IDLE
- cfg_npix_in  input  $clog2(DEPTH+1)  pixels per pass; 0 or >DEPTH treated as 1 / DEPTH
- cfg_npass_in  input  8  passes per tile; 0 treated as 1
- act_valid_in  input  1  controller injected one pixel into column lane 0 this cycle
- col_psum_out  output  WIDTH*O_CH  to column psum_in; lane k at [WIDTH*(O_CH-k)-1 -: WIDTH]
- col_psum_in  input  WIDTH*O_CH  from column psum_out; same lane packing
- thr_in  input  WIDTH  signed binarization threshold (width O_CH*WIDTH under PER_CH_THR_EN)
- out_valid_out  output  1  binarized word available
- out_ready_in  input  1  consumer accepts
- out_data_out  output  O_CH  bit k = lane k result, MSB = lane 0
- out_idx_out  output  $clog2(DEPTH)  pixel index of out_data_out
- busy_out  output  1  high when not IDLE

## Operation
- Storage: per lane, DEPTH x WIDTH entries buf[k][p]. Buffer contents are not reset.
- FSM states are IDLE, ACCUM, DRAIN and EMIT.
- IDLE: on cfg_valid_in, latch npix/npass, clear pix_cnt/pass_cnt, go to ACCUM.
- ACCUM, issue: each act_valid_in cycle pushes a tag {valid, p=pix_cnt, first=(pass_cnt==0)} into tag pipeline stage 0. Then pix_cnt increments; on wrap to 0, pass_cnt increments.
- ACCUM, exit: when the tag for the last pixel of the last pass is pushed, go to DRAIN on the next cycle.
- Tag pipeline: it is O_CH-1+PE_LAT stages deep. tag[j] is the stage-0 tag delayed j cycles.
- Read, lane k: col_psum_out lane k = (tag[k].valid && !tag[k].first) ? buf[k][tag[k].p] : 0.
- Write, lane k: when tag[k+PE_LAT].valid, buf[k][tag[k+PE_LAT].p] <= col_psum_in lane k.
- Forwarding: if lane k reads and writes the same address in the same cycle, the read returns col_psum_in lane k.
- Reuse constraint: npix >= PE_LAT is guaranteed by the controller; no further hazard handling.
- DRAIN: act_valid_in is ignored. Count O_CH-1+PE_LAT cycles until the pipeline is empty, then go to EMIT with emit_idx=0.
- EMIT: out_valid_out=1. out_data_out bit k = ($signed(buf[k][emit_idx]) >= $signed(thr_in)); out_idx_out=emit_idx.
- EMIT advance: on out_valid_out && out_ready_in, emit_idx increments. Acceptance of index npix-1 returns the FSM to IDLE.
- act_valid_in outside ACCUM: ignored, and no tag is pushed.
- cfg_valid_in outside IDLE: ignored.

## Timing
- Reset: the next edge forces IDLE, all tags invalid and all counters 0.
- Output values in reset and IDLE: cfg_ready_out=1, busy_out=0, out_valid_out=0, col_psum_out=0, out_data_out=0, out_idx_out=0.
- Pipeline alignment: a pixel issued at cycle t is presented to lane k at cycle t+k. Its result is written at the edge ending cycle t+k+PE_LAT.
- First output: out_valid_out rises O_CH+PE_LAT cycles after the last act_valid_in (one exit cycle plus the drain).
- Throughput: one output per cycle while out_ready_in is held high.
- Stall: while out_ready_in=0, out_data_out and out_idx_out are held stable.
- Reset mid-operation: in-flight tags are discarded and no further writes occur. Partial buffer contents are don't-care.
- col_psum_out and out_data_out are combinational from registered state and buffer. There is no combinational path from col_psum_in except the forwarding mux.

## Configuration
- PER_CH_THR_EN defined: thr_in is O_CH*WIDTH bits, packed like the psum buses, and lane k compares against its own threshold (batch-norm fold).
- PER_CH_THR_EN undefined: a single WIDTH-bit thr_in is shared by all lanes.

## Test plan
- Single pass, single pixel: npix=1, npass=1, column model out=in+7, thr=7.
  - All lanes see psum_in=0.
  - out_data_out=all ones, out_idx_out=0.
  - Then the block is back in IDLE.
- Multi-pass accumulation: npix=4, npass=3, model +5 per pass.
  - Lane k psum_in on pass 2 = 5, on pass 3 = 10; final buf = 15.
  - With thr=15, emits 4 words of all ones, idx 0..3.
  - With thr=16, emits all zeros.
- Forwarding: npix=1, npass=4, act_valid_in on 4 consecutive cycles, PE_LAT=1, model +3.
  - Final psum on every lane = 12.
- Skew: model output = lane index k.
  - npix=2, npass=1, thr=32: bit k = (k>=32), MSB half 0.
- Backpressure: out_ready_in low for 5 cycles mid-EMIT.
  - Data and idx held stable; no index skipped or repeated.
- Reset mid-ACCUM after 2 pixels.
  - Next cycle: cfg_ready_out=1, busy_out=0, col_psum_out=0.
  - act_valid_in pulses in IDLE and DRAIN cause no writes.

Source files
------------

// File: rtl/psum_collector_if.sv
// psum_collector_if: bundles the configuration, activation strobe, column psum buses,
// threshold and binarized-output handshake of psum_collector.
// Ports: master = controller/column/consumer side, slave = psum_collector side.
// Macro PER_CH_THR_EN widens thr_in to one WIDTH-bit threshold per lane.
interface psum_collector_if #(
  parameter int WIDTH = 14,
  parameter int O_CH  = 64,
  parameter int DEPTH = 16
);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    cfg_valid_in;
  logic                    cfg_ready_out;
  logic [NW-1:0]           cfg_npix_in;
  logic [7:0]              cfg_npass_in;
  logic                    act_valid_in;
  logic [WIDTH*O_CH-1:0]   col_psum_out;
  logic [WIDTH*O_CH-1:0]   col_psum_in;
`ifdef PER_CH_THR_EN
  logic [O_CH*WIDTH-1:0]   thr_in;
`else
  logic [WIDTH-1:0]        thr_in;
`endif
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [O_CH-1:0]         out_data_out;
  logic [IW-1:0]           out_idx_out;
  logic                    busy_out;

  modport master (
    output cfg_valid_in, cfg_npix_in, cfg_npass_in, act_valid_in, col_psum_in, thr_in, out_ready_in,
    input  cfg_ready_out, col_psum_out, out_valid_out, out_data_out, out_idx_out, busy_out
  );

  modport slave (
    input  cfg_valid_in, cfg_npix_in, cfg_npass_in, act_valid_in, col_psum_in, thr_in, out_ready_in,
    output cfg_ready_out, col_psum_out, out_valid_out, out_data_out, out_idx_out, busy_out
  );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: output-stationary partial-sum buffer under a skewed PE column; accumulates
//   npass passes over npix pixels per lane, then binarizes each pixel's sums against thr_in.
// Latency: lane k sees pixel t at cycle t+k; first output word O_CH+PE_LAT cycles after last pixel.
// Backpressure: EMIT holds out_data_out/out_idx_out while out_ready_in is low; cfg accepted only in IDLE.
// Ports: clk_in, rst_in (sync, active-high) plus psum_collector_if.slave bus.
// Macro PER_CH_THR_EN: per-lane thresholds packed like the psum buses (default: one shared threshold).
module psum_collector #(
  parameter int WIDTH  = 14,
  parameter int O_CH   = 64,
  parameter int DEPTH  = 16,
  parameter int PE_LAT = 1
) (
  input logic              clk_in,
  input logic              rst_in,
  psum_collector_if.slave  bus
);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NT = O_CH - 1 + PE_LAT;   // registered tag stages
  localparam int DW = $clog2(NT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic [IW-1:0] p;
  } tag_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   npix_q;
  logic [7:0]      npass_q;
  logic [IW-1:0]   pix_cnt_q;
  logic [7:0]      pass_cnt_q;
  logic [DW-1:0]   drain_cnt_q;
  logic [IW-1:0]   emit_idx_q;

  logic [NW-1:0]   npix_norm;
  logic [7:0]      npass_norm;
  logic            push, pix_wrap, emit_en, emit_acc;
  logic            cfg_ready, busy;

  tag_t            tag0;                  // stage 0 is combinational: lane 0 is served in the issue cycle
  tag_t [NT-1:0]   tag_q;                 // tag_q[i] holds stage i+1
  tag_t [NT:0]     tag_all;

  logic [WIDTH*O_CH-1:0] col_out;
  logic [O_CH-1:0]       out_bits;

  always_comb begin
    npix_norm = bus.cfg_npix_in;
    if (bus.cfg_npix_in == '0)
      npix_norm = NW'(1);
    else if (bus.cfg_npix_in > NW'(DEPTH))
      npix_norm = NW'(DEPTH);
    npass_norm = (bus.cfg_npass_in == 8'd0) ? 8'd1 : bus.cfg_npass_in;
  end

  assign pix_wrap = (NW'(pix_cnt_q) == npix_q - NW'(1));

  // Next state and strobes
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    busy      = 1'b1;
    push      = 1'b0;
    emit_en   = 1'b0;
    emit_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (bus.cfg_valid_in)
          state_d = ACCUM;
      end
      ACCUM: begin
        if (bus.act_valid_in) begin
          push = 1'b1;
          if (pix_wrap && (pass_cnt_q == npass_q - 8'd1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DW'(NT - 1))
          state_d = EMIT;
      end
      EMIT: begin
        emit_en  = 1'b1;
        emit_acc = bus.out_ready_in;
        if (bus.out_ready_in && (NW'(emit_idx_q) == npix_q - NW'(1)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag0       = '0;
    tag0.valid = push;
    tag0.first = (pass_cnt_q == 8'd0);
    tag0.p     = pix_cnt_q;
  end

  assign tag_all = {tag_q, tag0};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      npix_q      <= '0;
      npass_q     <= '0;
      pix_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      drain_cnt_q <= '0;
      emit_idx_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_all[NT-1:0];
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid_in) begin
            npix_q      <= npix_norm;
            npass_q     <= npass_norm;
            pix_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            drain_cnt_q <= '0;
          end
        end
        ACCUM: begin
          if (push) begin
            if (pix_wrap) begin
              pix_cnt_q  <= '0;
              pass_cnt_q <= pass_cnt_q + 8'd1;
            end else begin
              pix_cnt_q <= pix_cnt_q + IW'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + DW'(1);
          emit_idx_q  <= '0;
        end
        EMIT: begin
          if (emit_acc)
            emit_idx_q <= emit_idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < O_CH; k++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pin, thr_k;
    tag_t             rt, wt;
    logic             rd, fwd;

    assign rt  = tag_all[k];
    assign wt  = tag_all[k + PE_LAT];
    assign pin = bus.col_psum_in[WIDTH*(O_CH-k)-1 -: WIDTH];
    assign rd  = rt.valid && !rt.first;
    // Back-to-back passes over the same pixel: the result being written this cycle is the one to read.
    assign fwd = wt.valid && (wt.p == rt.p);

    assign col_out[WIDTH*(O_CH-k)-1 -: WIDTH] = !rd ? '0 : (fwd ? pin : mem[rt.p]);

    always_ff @(posedge clk_in) begin
      if (!rst_in && wt.valid)
        mem[wt.p] <= pin;
    end

`ifdef PER_CH_THR_EN
    assign thr_k = bus.thr_in[WIDTH*(O_CH-k)-1 -: WIDTH];
`else
    assign thr_k = bus.thr_in;
`endif

    assign out_bits[O_CH-1-k] = emit_en && ($signed(mem[emit_idx_q]) >= $signed(thr_k));
  end

  assign bus.cfg_ready_out = cfg_ready;
  assign bus.busy_out      = busy;
  assign bus.col_psum_out  = col_out;
  assign bus.out_valid_out = emit_en;
  assign bus.out_data_out  = out_bits;
  assign bus.out_idx_out   = emit_en ? emit_idx_q : '0;
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed scoreboard bench for psum_collector with a behavioural PE column
//   (psum_out = psum_in + delta, or + lane index) one cycle behind psum_in.
module tb_psum_collector;
  localparam int WIDTH  = 14;
  localparam int O_CH   = 64;
  localparam int DEPTH  = 16;
  localparam int PE_LAT = 1;
  localparam int IW     = $clog2(DEPTH);
  localparam int NW     = $clog2(DEPTH + 1);

  localparam logic [O_CH-1:0] ONES  = '1;
  localparam logic [O_CH-1:0] ZEROS = '0;
  localparam logic [O_CH-1:0] SKEW1 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [O_CH-1:0] SKEW2 = 64'h0000_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [O_CH-1:0] data;
    logic [IW-1:0]   idx;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  psum_collector_if #(.WIDTH(WIDTH), .O_CH(O_CH), .DEPTH(DEPTH)) bus ();

  psum_collector #(.WIDTH(WIDTH), .O_CH(O_CH), .DEPTH(DEPTH), .PE_LAT(PE_LAT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Column model
  int model_mode = 0;
  int delta      = 0;
  always @(posedge clk_in) begin
    for (int k = 0; k < O_CH; k++) begin
      bus.col_psum_in[WIDTH*(O_CH-k)-1 -: WIDTH] <= bus.col_psum_out[WIDTH*(O_CH-k)-1 -: WIDTH]
        + ((model_mode != 0) ? WIDTH'(k) : WIDTH'(delta));
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [O_CH-1:0] act, input logic [O_CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane_out(input int k);
    return bus.col_psum_out[WIDTH*(O_CH-k)-1 -: WIDTH];
  endfunction

  // Output monitor
  always @(negedge clk_in) begin
    if (!rst_in && bus.out_valid_out && bus.out_ready_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got idx %0d data %h, expected no output", bus.out_idx_out, bus.out_data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data_out, e.data);
        check("out_idx", O_CH'(bus.out_idx_out), O_CH'(e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_thr(input int t);
    logic [WIDTH-1:0] v;
    v = WIDTH'(t);
`ifdef PER_CH_THR_EN
    bus.thr_in = {O_CH{v}};
`else
    bus.thr_in = v;
`endif
  endtask

  task automatic configure(input int npix, input int npass);
    check("cfg_ready_idle", O_CH'(bus.cfg_ready_out), O_CH'(1));
    bus.cfg_npix_in  = NW'(npix);
    bus.cfg_npass_in = 8'(npass);
    bus.cfg_valid_in = 1'b1;
    tick();
    bus.cfg_valid_in = 1'b0;
    check("busy_after_cfg", O_CH'(bus.busy_out), O_CH'(1));
  endtask

  task automatic expect_words(input int n, input logic [O_CH-1:0] w);
    for (int i = 0; i < n; i++) exp_q.push_back('{data: w, idx: IW'(i)});
  endtask

  // Issues n pixels, checking lane 0's psum_in = step * (pass index) in each issue cycle.
  task automatic issue(input int n, input int npix, input int step, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.act_valid_in = 1'b1;
      #1;
      check("lane0_psum_in", O_CH'(lane_out(0)), O_CH'(step * (i / npix)));
      tick();
      bus.act_valid_in = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic drain_out(input int budget);
    int c;
    c = 0;
    bus.out_ready_in = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding after %0d cycles, expected 0", exp_q.size(), c);
      exp_q.delete();
    end
    check("idle_after_emit", O_CH'(bus.cfg_ready_out), O_CH'(1));
    check("not_busy_after_emit", O_CH'(bus.busy_out), O_CH'(0));
    check("no_valid_after_emit", O_CH'(bus.out_valid_out), O_CH'(0));
  endtask

  initial begin
    int   c;
    logic nz;
    bus.cfg_valid_in = 1'b0;
    bus.cfg_npix_in  = '0;
    bus.cfg_npass_in = '0;
    bus.act_valid_in = 1'b0;
    bus.out_ready_in = 1'b0;
    bus.col_psum_in  = '0;
    set_thr(0);

    // Reset state
    rst_in = 1'b1;
    repeat (3) tick();
    check("rst_cfg_ready", O_CH'(bus.cfg_ready_out), O_CH'(1));
    check("rst_busy", O_CH'(bus.busy_out), O_CH'(0));
    check("rst_valid", O_CH'(bus.out_valid_out), O_CH'(0));
    check("rst_col_zero", O_CH'(bus.col_psum_out == '0), O_CH'(1));
    check("rst_data", bus.out_data_out, ZEROS);
    check("rst_idx", O_CH'(bus.out_idx_out), O_CH'(0));
    rst_in = 1'b0;
    tick();

    // Single pass, single pixel; first-output latency
    model_mode = 0; delta = 7; set_thr(7);
    configure(1, 1);
    expect_words(1, ONES);
    issue(1, 1, 0, 0);
    c = 0; nz = 1'b0;
    while (!bus.out_valid_out && c < 200) begin
      if (bus.col_psum_out != '0) nz = 1'b1;
      tick();
      c++;
    end
    check("first_pass_lanes_zero", O_CH'(nz), O_CH'(0));
    check("first_valid_latency", O_CH'(c + 1), O_CH'(O_CH + PE_LAT));
    drain_out(20);

    // Multi-pass accumulation, threshold at and above the final sum of 15
    delta = 5; set_thr(15);
    configure(4, 3);
    expect_words(4, ONES);
    issue(12, 4, 5, 0);
    drain_out(200);
    set_thr(16);
    configure(4, 3);
    expect_words(4, ZEROS);
    issue(12, 4, 5, 0);
    drain_out(200);

    // Forwarding: same pixel on consecutive cycles, final sum 12
    delta = 3; set_thr(12);
    configure(1, 4);
    expect_words(1, ONES);
    issue(4, 1, 3, 0);
    drain_out(200);
    set_thr(13);
    configure(1, 4);
    expect_words(1, ZEROS);
    issue(4, 1, 3, 0);
    drain_out(200);

    // Skew: column adds the lane index
    model_mode = 1; set_thr(32);
    configure(2, 1);
    expect_words(2, SKEW1);
    issue(2, 2, 0, 2);
    drain_out(200);
    configure(2, 2);
    expect_words(2, SKEW2);
    issue(4, 2, 0, 1);
    drain_out(200);

    // Backpressure mid-EMIT; a cfg strobe during ACCUM must be ignored
    model_mode = 0; delta = 7; set_thr(7);
    configure(4, 1);
    expect_words(4, ONES);
    bus.cfg_npix_in  = NW'(1);
    bus.cfg_valid_in = 1'b1;
    tick();
    bus.cfg_valid_in = 1'b0;
    issue(4, 4, 0, 0);
    bus.out_ready_in = 1'b1;
    c = 0;
    while (exp_q.size() > 2 && c < 200) begin
      tick();
      c++;
    end
    check("reach_stall_point", O_CH'(exp_q.size()), O_CH'(2));
    bus.out_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", O_CH'(bus.out_valid_out), O_CH'(1));
      check("stall_idx", O_CH'(bus.out_idx_out), O_CH'(2));
      check("stall_data", bus.out_data_out, ONES);
      tick();
    end
    drain_out(20);

    // Reset mid-ACCUM after two pixels, then activity in IDLE
    configure(4, 1);
    issue(2, 4, 0, 0);
    rst_in = 1'b1;
    tick();
    check("midrst_cfg_ready", O_CH'(bus.cfg_ready_out), O_CH'(1));
    check("midrst_busy", O_CH'(bus.busy_out), O_CH'(0));
    check("midrst_col_zero", O_CH'(bus.col_psum_out == '0), O_CH'(1));
    check("midrst_valid", O_CH'(bus.out_valid_out), O_CH'(0));
    rst_in = 1'b0;
    bus.act_valid_in = 1'b1;
    tick();
    check("idle_act_col_zero", O_CH'(bus.col_psum_out == '0), O_CH'(1));
    check("idle_act_busy", O_CH'(bus.busy_out), O_CH'(0));
    tick();
    bus.act_valid_in = 1'b0;

    // act_valid_in during DRAIN must not add another pass (final 7 stays below 8)
    delta = 7; set_thr(8);
    configure(1, 1);
    expect_words(1, ZEROS);
    issue(1, 1, 0, 0);
    bus.act_valid_in = 1'b1;
    repeat (5) tick();
    bus.act_valid_in = 1'b0;
    drain_out(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
